lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and the byte-addressed data memory. Accepts one RV32I load/store per handshake, decodes funct3, and drives the memory's word-wide port (address, write enable, write data, combinational read data). It does sign/zero extension for loads and read-modify-write for SB/SH, because the memory only writes all four bytes at once. Results and faults return to writeback through a valid/ready response channel.

## Interface
- NB_DATA, 32, data width
- NB_ADDR, 32, address width driven to memory
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  LSU can accept a request (IDLE only)
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I funct3
- i_req_addr  in  NB_ADDR  byte address (rs1 + imm)
- i_req_wdata  in  NB_DATA  store data (rs2)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_rdata  out  NB_DATA  extended load data; 0 for stores and faults
- o_rsp_fault  out  1  illegal funct3 or, if enabled, misaligned
- o_dmem_address  out  NB_ADDR  memory byte address
- o_dmem_wr_enable  out  1  4-byte write at o_dmem_address on next edge
- o_dmem_wr_data  out  NB_DATA  write data, byte 0 at o_dmem_address
- i_dmem_rd_data  in  NB_DATA  combinational read, byte 0 at o_dmem_address

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: o_req_ready=1. On i_req_valid, register we/funct3/addr/wdata, then:
  - illegal funct3 (load: 011, 110, 111; store: anything other than 000/001/010) -> RESP with fault
  - load -> LOAD; SW -> STORE; SB/SH -> RMW_RD
- LOAD: drive the registered address and capture i_dmem_rd_data. LB/LBU use bits [7:0]; LH/LHU use [15:0]; LW uses all 32. LB/LH sign-extend; LBU/LHU zero-extend. Go to RESP.
- STORE: o_dmem_wr_enable=1, o_dmem_wr_data=wdata. Go to RESP.
- RMW_RD: drive the address and capture i_dmem_rd_data into a merge register. Go to RMW_WR.
- RMW_WR: o_dmem_wr_enable=1. Write data is the merge register with bits [7:0] (SB) or [15:0] (SH) replaced by the matching wdata bits. Upper bytes are written back unchanged. Go to RESP.
- RESP: o_rsp_valid=1 and response outputs stay stable until i_rsp_ready=1, then go to IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- o_dmem_wr_enable is asserted only in STORE and RMW_WR, for exactly one cycle per store. Faulted requests never touch memory.
- Address arithmetic is unsigned, truncated to NB_ADDR. No range check; addresses wrap.

## Timing
- Reset values: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_fault=0, o_dmem_address=0, o_dmem_wr_enable=0, o_dmem_wr_data=0.
- Reset at any point, including mid-RMW or while RESP is stalled, returns to IDLE on that edge. The pending response is dropped. o_dmem_wr_enable is 0 from the next cycle, so an RMW_RD aborted by reset writes nothing.
- With accept at cycle 0 and i_rsp_ready held high, o_rsp_valid asserts at:
  - load, SW: cycle 2
  - SB/SH: cycle 3
  - fault: cycle 1
- o_dmem_address holds the registered address in LOAD, STORE, RMW_RD and RMW_WR, and is 0 in IDLE and RESP.
- o_dmem_wr_data is 0 whenever o_dmem_wr_enable is 0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a halfword access with addr[0]≠0, or a word access with addr[1:0]≠0, goes IDLE -> RESP with o_rsp_fault=1 and no memory access.
- Not defined: misaligned accesses execute normally, because the memory is byte-addressed. o_rsp_fault is raised only for illegal funct3.

## Test plan
- Memory bytes at 0x10..0x13 = 80 FF 34 12. LW 0x10 -> rdata 0x1234FF80, valid at cycle 2. LB -> 0xFFFFFF80. LBU -> 0x00000080. LH -> 0xFFFFFF80. LHU -> 0x0000FF80.
- Word at 0x20 = 0xAABBCCDD, then SB 0x20 with wdata 0x11. Exactly one write pulse, with data 0xAABBCC11. A follow-up LW 0x20 -> 0xAABBCC11.
- SH 0x21 with wdata 0x5566 over word 0xAABBCCDD at 0x21:
  - without the macro: bytes 0x21..0x22 = 66 55 and 0x23 unchanged
  - with LSU_MISALIGN_TRAP_EN: fault, no write pulse, rdata 0
- Load with funct3=011 -> fault at cycle 1 and no memory access. Store with funct3=100 -> fault.
- Hold i_rsp_ready=0 for 5 cycles after a load. o_rsp_valid and rdata stay stable, o_req_ready stays 0, and a queued request is accepted the cycle after the handshake.
- Assert i_reset during RMW_RD of an SB. No write pulse occurs, outputs return to reset values, and the target word is unchanged.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: funct3 decode, load extension and read-modify-write for SB/SH
// over a word-wide memory port. Optional misalignment trapping via LSU_MISALIGN_TRAP_EN.

module lsu_checker #(
    parameter int NB_DATA = 32
) (
    input logic               clk,
    input logic               rst,
    input logic               req_ready,
    input logic               rsp_valid,
    input logic               rsp_ready,
    input logic [NB_DATA-1:0] rsp_rdata,
    input logic               rsp_fault,
    input logic               wr_enable,
    input logic [NB_DATA-1:0] wr_data
);

    // Reset must land every output in its idle value on the following cycle.
    a_reset_idle: assert property (@(posedge clk)
        rst |=> (req_ready && !rsp_valid && !wr_enable));

    a_wdata_zero: assert property (@(posedge clk) disable iff (rst)
        !wr_enable |-> (wr_data == {NB_DATA{1'b0}}));

    a_single_write: assert property (@(posedge clk) disable iff (rst)
        wr_enable |=> !wr_enable);

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_fault)));

    a_ready_excl: assert property (@(posedge clk) disable iff (rst)
        !(req_ready && rsp_valid));

endmodule

module lsu #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [2:0]         i_req_funct3,
    input  logic [NB_ADDR-1:0] i_req_addr,
    input  logic [NB_DATA-1:0] i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_rdata,
    output logic               o_rsp_fault,
    output logic [NB_ADDR-1:0] o_dmem_address,
    output logic               o_dmem_wr_enable,
    output logic [NB_DATA-1:0] o_dmem_wr_data,
    input  logic [NB_DATA-1:0] i_dmem_rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    function automatic logic [NB_DATA-1:0] load_extend(input logic [2:0] f3,
                                                       input logic [NB_DATA-1:0] d);
        case (f3)
            3'b000:  load_extend = {{(NB_DATA-8){d[7]}}, d[7:0]};
            3'b001:  load_extend = {{(NB_DATA-16){d[15]}}, d[15:0]};
            3'b010:  load_extend = d;
            3'b100:  load_extend = {{(NB_DATA-8){1'b0}}, d[7:0]};
            3'b101:  load_extend = {{(NB_DATA-16){1'b0}}, d[15:0]};
            default: load_extend = {NB_DATA{1'b0}};
        endcase
    endfunction

    // Only the low byte or halfword of the old word is replaced; upper bytes are written back.
    function automatic logic [NB_DATA-1:0] store_merge(input logic is_half,
                                                       input logic [NB_DATA-1:0] old_word,
                                                       input logic [15:0] wd);
        if (is_half) begin
            store_merge = {old_word[NB_DATA-1:16], wd[15:0]};
        end else begin
            store_merge = {old_word[NB_DATA-1:8], wd[7:0]};
        end
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            funct3_illegal = f3[2] | (f3[1:0] == 2'b11);
        end else begin
            funct3_illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        end
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [2:0]         funct3_r;
    logic [NB_ADDR-1:0] addr_r;
    logic [15:0]        wdata_r;
    logic               misalign_s;

    logic               req_ready_r,      req_ready_s;
    logic               rsp_valid_r,      rsp_valid_s;
    logic [NB_DATA-1:0] rsp_rdata_r,      rsp_rdata_s;
    logic               rsp_fault_r,      rsp_fault_s;
    logic [NB_ADDR-1:0] dmem_address_r,   dmem_address_s;
    logic               dmem_wr_enable_r, dmem_wr_enable_s;
    logic [NB_DATA-1:0] dmem_wr_data_r,   dmem_wr_data_s;

    // Misaligned halfword/word detection for the incoming request.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
    end

    // Next state and next registered output values.
    always_comb begin
        state_s          = state_r;
        req_ready_s      = 1'b0;
        rsp_valid_s      = 1'b0;
        rsp_rdata_s      = {NB_DATA{1'b0}};
        rsp_fault_s      = 1'b0;
        dmem_address_s   = {NB_ADDR{1'b0}};
        dmem_wr_enable_s = 1'b0;
        dmem_wr_data_s   = {NB_DATA{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (funct3_illegal(i_req_we, i_req_funct3) || misalign_s) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_fault_s = 1'b1;
                    end else if (!i_req_we) begin
                        state_s        = ST_LOAD;
                        dmem_address_s = i_req_addr;
                    end else if (i_req_funct3[1]) begin
                        state_s          = ST_STORE;
                        dmem_address_s   = i_req_addr;
                        dmem_wr_enable_s = 1'b1;
                        dmem_wr_data_s   = i_req_wdata;
                    end else begin
                        state_s        = ST_RMW_RD;
                        dmem_address_s = i_req_addr;
                    end
                end else begin
                    req_ready_s = 1'b1;
                end
            end
            ST_LOAD: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
                rsp_rdata_s = load_extend(funct3_r, i_dmem_rd_data);
            end
            ST_STORE: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
            end
            ST_RMW_RD: begin
                // The write-data register doubles as the merge register.
                state_s          = ST_RMW_WR;
                dmem_address_s   = addr_r;
                dmem_wr_enable_s = 1'b1;
                dmem_wr_data_s   = store_merge(funct3_r[0], i_dmem_rd_data, wdata_r);
            end
            ST_RMW_WR: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_s     = ST_IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = rsp_rdata_r;
                    rsp_fault_s = rsp_fault_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            funct3_r <= 3'b000;
            addr_r   <= {NB_ADDR{1'b0}};
            wdata_r  <= 16'h0000;
        end else if ((state_r == ST_IDLE) && i_req_valid) begin
            funct3_r <= i_req_funct3;
            addr_r   <= i_req_addr;
            wdata_r  <= i_req_wdata[15:0];
        end else begin
            funct3_r <= funct3_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            req_ready_r      <= 1'b1;
            rsp_valid_r      <= 1'b0;
            rsp_rdata_r      <= {NB_DATA{1'b0}};
            rsp_fault_r      <= 1'b0;
            dmem_address_r   <= {NB_ADDR{1'b0}};
            dmem_wr_enable_r <= 1'b0;
            dmem_wr_data_r   <= {NB_DATA{1'b0}};
        end else begin
            req_ready_r      <= req_ready_s;
            rsp_valid_r      <= rsp_valid_s;
            rsp_rdata_r      <= rsp_rdata_s;
            rsp_fault_r      <= rsp_fault_s;
            dmem_address_r   <= dmem_address_s;
            dmem_wr_enable_r <= dmem_wr_enable_s;
            dmem_wr_data_r   <= dmem_wr_data_s;
        end
    end

    assign o_req_ready      = req_ready_r;
    assign o_rsp_valid      = rsp_valid_r;
    assign o_rsp_rdata      = rsp_rdata_r;
    assign o_rsp_fault      = rsp_fault_r;
    assign o_dmem_address   = dmem_address_r;
    assign o_dmem_wr_enable = dmem_wr_enable_r;
    assign o_dmem_wr_data   = dmem_wr_data_r;

    lsu_checker #(.NB_DATA(NB_DATA)) u_checker (
        .clk       (i_clock),
        .rst       (i_reset),
        .req_ready (req_ready_r),
        .rsp_valid (rsp_valid_r),
        .rsp_ready (i_rsp_ready),
        .rsp_rdata (rsp_rdata_r),
        .rsp_fault (rsp_fault_r),
        .wr_enable (dmem_wr_enable_r),
        .wr_data   (dmem_wr_data_r)
    );

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-array memory model, expected responses queued at issue
// and checked by an independent monitor.

module tb_lsu;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_fault;
    logic [31:0] o_dmem_address;
    logic        o_dmem_wr_enable;
    logic [31:0] o_dmem_wr_data;
    logic [31:0] i_dmem_rd_data;

    lsu #(.NB_DATA(32), .NB_ADDR(32)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_we         (i_req_we),
        .i_req_funct3     (i_req_funct3),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_rdata      (o_rsp_rdata),
        .o_rsp_fault      (o_rsp_fault),
        .o_dmem_address   (o_dmem_address),
        .o_dmem_wr_enable (o_dmem_wr_enable),
        .o_dmem_wr_data   (o_dmem_wr_data),
        .i_dmem_rd_data   (i_dmem_rd_data)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Memory model: 256 bytes, little-endian, addresses wrap.
    logic [7:0]  mem [0:255];
    logic        poke_en   = 1'b0;
    logic [7:0]  poke_addr = 8'h00;
    logic [31:0] poke_data = 32'h0;
    int          wr_count  = 0;
    logic [31:0] last_wr_data = 32'h0;
    logic [7:0]  ra0, ra1, ra2, ra3;

    always_comb begin
        ra0 = o_dmem_address[7:0];
        ra1 = ra0 + 8'd1;
        ra2 = ra0 + 8'd2;
        ra3 = ra0 + 8'd3;
        i_dmem_rd_data = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
    end

    always @(posedge i_clock) begin
        if (poke_en) begin
            mem[poke_addr]        <= poke_data[7:0];
            mem[poke_addr + 8'd1] <= poke_data[15:8];
            mem[poke_addr + 8'd2] <= poke_data[23:16];
            mem[poke_addr + 8'd3] <= poke_data[31:24];
        end else if (o_dmem_wr_enable) begin
            mem[ra0]     <= o_dmem_wr_data[7:0];
            mem[ra1]     <= o_dmem_wr_data[15:8];
            mem[ra2]     <= o_dmem_wr_data[23:16];
            mem[ra3]     <= o_dmem_wr_data[31:24];
            wr_count     <= wr_count + 1;
            last_wr_data <= o_dmem_wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented response against the head of the scoreboard.
    initial begin : monitor
        int   cyc;
        int   acc_cyc;
        logic prev_valid;
        exp_t e;
        cyc = 0;
        acc_cyc = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge i_clock);
            cyc++;
            if (i_reset) begin
                prev_valid = 1'b0;
            end else begin
                if (i_req_valid && o_req_ready) acc_cyc = cyc;
                if (o_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_rsp", 32'(o_rsp_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        check({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
                        check({e.name, "_fault"}, 32'(o_rsp_fault), 32'(e.fault));
                        check({e.name, "_req_ready"}, 32'(o_req_ready), 32'd0);
                        if (!prev_valid) check({e.name, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
                        if (i_rsp_ready) void'(exp_q.pop_front());
                    end
                end
                if (!o_dmem_wr_enable) check("wdata_zero_when_idle", o_dmem_wr_data, 32'd0);
                else check("wr_addr_upper", {8'd0, o_dmem_address[31:8]}, 32'd0);
                prev_valid = o_rsp_valid && !i_rsp_ready;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] rd, input logic f, input int lat);
        exp_t e;
        e.rdata = rd; e.fault = f; e.lat = lat; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic acc;
        acc = 1'b0;
        i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
        i_req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc = o_req_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (o_req_ready) break;
            tick();
        end
        check("return_to_idle", 32'(o_req_ready), 32'd1);
    endtask

    task automatic run(input string name, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic f, input int lat);
        expect_rsp(name, rd, f, lat);
        issue(we, f3, a, wd);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, 32'd0);
        check({tag, "_rsp_fault"}, 32'(o_rsp_fault), 32'd0);
        check({tag, "_dmem_addr"}, o_dmem_address, 32'd0);
        check({tag, "_wr_enable"}, 32'(o_dmem_wr_enable), 32'd0);
        check({tag, "_wr_data"}, o_dmem_wr_data, 32'd0);
    endtask

    initial begin : stimulus
        int w0;
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'b000;
        i_req_addr = 32'h0; i_req_wdata = 32'h0; i_rsp_ready = 1'b1;
        tick();
        poke(8'h10, 32'h1234FF80);
        poke(8'h20, 32'hAABBCCDD);
        poke(8'h24, 32'h00000000);
        poke(8'h30, 32'h00000000);
        poke(8'h40, 32'h01020304);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        tick();

        run("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1234FF80, 1'b0, 2);
        run("lb",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run("lbu", 1'b0, 3'b100, 32'h10, 32'h0, 32'h00000080, 1'b0, 2);
        run("lh",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        run("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000FF80, 1'b0, 2);

        w0 = wr_count;
        run("sb", 1'b1, 3'b000, 32'h20, 32'hDEADBE11, 32'h0, 1'b0, 3);
        check("sb_write_pulses", 32'(wr_count - w0), 32'd1);
        check("sb_write_data", last_wr_data, 32'hAABBCC11);
        run("lw_after_sb", 1'b0, 3'b010, 32'h20, 32'h0, 32'hAABBCC11, 1'b0, 2);

        w0 = wr_count;
        run("sw", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        check("sw_write_pulses", 32'(wr_count - w0), 32'd1);
        run("lw_after_sw", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 2);

        poke(8'h20, 32'hAABBCCDD);
        w0 = wr_count;
`ifdef LSU_MISALIGN_TRAP_EN
        run("sh_misaligned", 1'b1, 3'b001, 32'h21, 32'h12345566, 32'h0, 1'b1, 1);
        check("sh_write_pulses", 32'(wr_count - w0), 32'd0);
        check("sh_bytes", {8'd0, mem[8'h23], mem[8'h22], mem[8'h21]}, 32'h00AABBCC);
`else
        run("sh_misaligned", 1'b1, 3'b001, 32'h21, 32'h12345566, 32'h0, 1'b0, 3);
        check("sh_write_pulses", 32'(wr_count - w0), 32'd1);
        check("sh_write_data", last_wr_data, 32'h00AA5566);
        check("sh_bytes", {8'd0, mem[8'h23], mem[8'h22], mem[8'h21]}, 32'h00AA5566);
`endif

        w0 = wr_count;
        run("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        run("st_f3_100", 1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        check("fault_write_pulses", 32'(wr_count - w0), 32'd0);
        check("fault_mem_intact", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'hCAFEF00D);

        // Stalled response with a second request waiting behind it.
        i_rsp_ready = 1'b0;
        expect_rsp("stall_lw", 32'h1234FF80, 1'b0, 2);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        expect_rsp("queued_lbu", 32'h00000080, 1'b0, 2);
        i_req_we = 1'b0; i_req_funct3 = 3'b100; i_req_addr = 32'h10; i_req_wdata = 32'h0;
        i_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (o_rsp_valid) break;
            tick();
        end
        repeat (5) tick();
        check("stall_req_ready", 32'(o_req_ready), 32'd0);
        i_rsp_ready = 1'b1;
        tick();
        check("after_handshake_ready", 32'(o_req_ready), 32'd1);
        tick();
        check("queued_accepted", 32'(o_req_ready), 32'd0);
        i_req_valid = 1'b0;
        wait_idle();

        // Reset while the SB is in its read phase.
        w0 = wr_count;
        issue(1'b1, 3'b000, 32'h40, 32'h000000FF);
        i_reset = 1'b1;
        tick();
        check_reset_outputs("rmw_abort");
        i_reset = 1'b0;
        repeat (3) tick();
        check("rmw_abort_pulses", 32'(wr_count - w0), 32'd0);
        check("rmw_abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h01020304);
        run("lw_after_reset", 1'b0, 3'b010, 32'h40, 32'h0, 32'h01020304, 1'b0, 2);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
